// File: rtl/scan_step_ctrl.sv
// scan_step_ctrl: raster scan sequencer stepping X/Y on each rising edge of m50.
// Define SCAN_SERPENTINE_EN to flip x_dir on every line advance (serpentine scan).
module scan_step_ctrl #(
    parameter int CNT_W   = 16,
    parameter int PULSE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m50,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_pts,
    input  logic [CNT_W-1:0] n_lines,
    output logic             x_step,
    output logic             x_dir,
    output logic             y_step,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] x_idx,
    output logic [CNT_W-1:0] y_idx
);
    typedef enum logic [1:0] {IDLE, RUN_X, LINE, FINISH} state_t;

    localparam logic [4:0]       PW  = 5'(PULSE_W);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q;
    logic             m50_q;
    logic             busy_q;
    logic             done_q;
    logic [4:0]       xcnt_q;
    logic [4:0]       ycnt_q;
    logic [CNT_W-1:0] npts_q;
    logic [CNT_W-1:0] nlines_q;
    logic [CNT_W-1:0] x_idx_q;
    logic [CNT_W-1:0] y_idx_q;
    logic [CNT_W-1:0] x_idx_d;
    logic [CNT_W-1:0] y_idx_d;
    logic             tick;

`ifdef SCAN_SERPENTINE_EN
    logic dir_q;
    assign x_dir = dir_q;
`else
    assign x_dir = 1'b1;
`endif

    // m50 is generated from clk, so a single register gives the edge
    assign tick    = m50 & ~m50_q;
    assign x_idx_d = x_idx_q + ONE;
    assign y_idx_d = y_idx_q + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            m50_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            xcnt_q   <= '0;
            ycnt_q   <= '0;
            npts_q   <= '0;
            nlines_q <= '0;
            x_idx_q  <= '0;
            y_idx_q  <= '0;
`ifdef SCAN_SERPENTINE_EN
            dir_q    <= 1'b1;
`endif
        end else begin
            m50_q  <= m50;
            done_q <= 1'b0;
            if (xcnt_q != 5'd0) xcnt_q <= xcnt_q - 5'd1;
            if (ycnt_q != 5'd0) ycnt_q <= ycnt_q - 5'd1;
            if (abort && state_q != IDLE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                xcnt_q  <= '0;
                ycnt_q  <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (n_pts != '0 && n_lines != '0) begin
                                npts_q   <= n_pts;
                                nlines_q <= n_lines;
                                x_idx_q  <= '0;
                                y_idx_q  <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= RUN_X;
`ifdef SCAN_SERPENTINE_EN
                                dir_q    <= 1'b1;
`endif
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    RUN_X: begin
                        if (tick) begin
                            xcnt_q  <= PW;
                            x_idx_q <= x_idx_d;
                            if (x_idx_d == npts_q) state_q <= LINE;
                        end
                    end
                    LINE: begin
                        if (tick) begin
                            if (y_idx_d == nlines_q) begin
                                state_q <= FINISH;
                            end else begin
                                ycnt_q  <= PW;
                                y_idx_q <= y_idx_d;
                                x_idx_q <= '0;
                                state_q <= RUN_X;
`ifdef SCAN_SERPENTINE_EN
                                dir_q   <= ~dir_q;
`endif
                            end
                        end
                    end
                    FINISH: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign x_step = (xcnt_q != 5'd0);
    assign y_step = (ycnt_q != 5'd0);
    assign busy   = busy_q;
    assign done   = done_q;
    assign x_idx  = x_idx_q;
    assign y_idx  = y_idx_q;

endmodule

// File: tb/tb_scan_step_ctrl.sv
// tb_scan_step_ctrl: scoreboard bench for scan_step_ctrl.
// Expected step/done events are queued at start and matched against observed ones.
module tb_scan_step_ctrl;
    localparam int CNT_W   = 16;
    localparam int PULSE_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             m50 = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] n_pts = '0;
    logic [CNT_W-1:0] n_lines = '0;
    logic             x_step;
    logic             x_dir;
    logic             y_step;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] x_idx;
    logic [CNT_W-1:0] y_idx;

    // kind: 1 = x_step rise, 2 = y_step rise, 3 = done (idx holds busy)
    typedef struct {
        int kind;
        int idx;
        int dir;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  wid_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  ph = 0;
    int  xw = 0;
    int  yw = 0;
    bit  px = 1'b0;
    bit  py = 1'b0;

    scan_step_ctrl #(.CNT_W(CNT_W), .PULSE_W(PULSE_W)) dut (
        .clk(clk), .rst(rst), .m50(m50), .start(start), .abort(abort),
        .n_pts(n_pts), .n_lines(n_lines), .x_step(x_step), .x_dir(x_dir),
        .y_step(y_step), .busy(busy), .done(done), .x_idx(x_idx), .y_idx(y_idx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // m50: 50-clk period, 50% duty, changes just after a clk edge
    initial forever begin
        @(posedge clk);
        #1;
        ph = (ph + 1) % 50;
        m50 = (ph >= 25);
    end

    initial forever begin
        ev_t ev;
        @(negedge clk);
        ev.dir = int'(x_dir);
        ev.cyc = cyc;
        if (x_step && !px) begin
            ev.kind = 1; ev.idx = int'(x_idx); obs_q.push_back(ev);
        end
        if (y_step && !py) begin
            ev.kind = 2; ev.idx = int'(y_idx); obs_q.push_back(ev);
        end
        if (done) begin
            ev.kind = 3; ev.idx = int'(busy); obs_q.push_back(ev);
        end
        if (x_step) xw++;
        else if (xw != 0) begin wid_q.push_back(xw); xw = 0; end
        if (y_step) yw++;
        else if (yw != 0) begin wid_q.push_back(yw); yw = 0; end
        px = x_step;
        py = y_step;
    end

    function automatic int dir_of(int l);
`ifdef SCAN_SERPENTINE_EN
        return (l % 2 == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    // c0 >= 0 gives the cycle of the first tick; events then fall every 50 clk
    task automatic push_frame(int np, int nl, int c0);
        ev_t ev;
        int  k;
        k = 0;
        for (int l = 0; l < nl; l++) begin
            for (int i = 1; i <= np; i++) begin
                ev.kind = 1; ev.idx = i; ev.dir = dir_of(l);
                ev.cyc = (c0 >= 0) ? c0 + 50 * k : -1;
                exp_q.push_back(ev); k++;
            end
            if (l < nl - 1) begin
                ev.kind = 2; ev.idx = l + 1; ev.dir = dir_of(l + 1);
                ev.cyc = (c0 >= 0) ? c0 + 50 * k : -1;
                exp_q.push_back(ev); k++;
            end
        end
        ev.kind = 3; ev.idx = 0; ev.dir = dir_of(nl - 1);
        ev.cyc = (c0 >= 0) ? c0 + 50 * k + 1 : -1;
        exp_q.push_back(ev);
    endtask

    task automatic do_start(int np, int nl, output int p);
        @(posedge clk);
        #1;
        n_pts = CNT_W'(np);
        n_lines = CNT_W'(nl);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        p = cyc;
    endtask

    task automatic wait_done(int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_all();
        exp_q.delete(); obs_q.delete(); wid_q.delete();
    endtask

    task automatic test_reset();
        bit hit;
        int p;
        @(negedge clk);
        tests++;
        if (x_step !== 1'b0 || y_step !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || x_dir !== 1'b1 || x_idx !== '0 || y_idx !== '0) begin
            fails++;
            $display("FAIL reset_init got xs%b ys%b b%b d%b dir%b xi%0d yi%0d want 0 0 0 0 1 0 0",
                     x_step, y_step, busy, done, x_dir, x_idx, y_idx);
        end
        rst = 1'b0;
        do_start(2, 3, p);
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (x_step && y_idx == 16'd1) begin hit = 1'b1; break; end
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL reset_reach got timeout want line1 x_step"); end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (x_step !== 1'b0 || y_step !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || x_dir !== 1'b1 || x_idx !== '0 || y_idx !== '0) begin
            fails++;
            $display("FAIL reset_async got xs%b ys%b b%b d%b dir%b xi%0d yi%0d want 0 0 0 0 1 0 0",
                     x_step, y_step, busy, done, x_dir, x_idx, y_idx);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_all();
        repeat (200) @(negedge clk);
        tests++;
        if (obs_q.size() != 0 || wid_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle got ev%0d pulses%0d busy%b want 0 0 0",
                     obs_q.size(), wid_q.size(), busy);
        end
        clear_all();
    endtask

    task automatic test_basic_frame();
        bit  ok;
        int  p;
        ev_t e, o;
        clear_all();
        do_start(3, 2, p);
        push_frame(3, 2, -1);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_done(700, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_done got timeout want done"); end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.kind != e.kind || o.idx != e.idx || o.dir != e.dir) begin
                fails++;
                $display("FAIL basic_ev got k%0d i%0d d%0d want k%0d i%0d d%0d",
                         o.kind, o.idx, o.dir, e.kind, e.idx, e.dir);
            end
        end
        tests++;
        if (wid_q.size() != 7) begin
            fails++; $display("FAIL basic_npulse got %0d want 7", wid_q.size());
        end
        foreach (wid_q[i]) begin
            tests++;
            if (wid_q[i] != PULSE_W) begin
                fails++; $display("FAIL basic_width got %0d want %0d", wid_q[i], PULSE_W);
            end
        end
        clear_all();
    endtask

    task automatic test_zero_size();
        int p;
        int np;
        int nl;
        for (int t = 0; t < 2; t++) begin
            clear_all();
            np = (t == 0) ? 0 : 3;
            nl = (t == 0) ? 5 : 0;
            do_start(np, nl, p);
            repeat (120) @(negedge clk);
            tests++;
            if (obs_q.size() != 1 || wid_q.size() != 0) begin
                fails++;
                $display("FAIL zero_count got ev%0d pulses%0d want 1 0", obs_q.size(), wid_q.size());
            end else if (obs_q[0].kind != 3 || obs_q[0].idx != 0 || obs_q[0].cyc != p) begin
                fails++;
                $display("FAIL zero_done got k%0d busy%0d c%0d want k3 busy0 c%0d",
                         obs_q[0].kind, obs_q[0].idx, obs_q[0].cyc, p);
            end
        end
        clear_all();
    endtask

    task automatic test_abort();
        bit  hit;
        int  p;
        ev_t e;
        clear_all();
        do_start(10, 10, p);
        for (int i = 1; i <= 4; i++) begin
            e.kind = 1; e.idx = i; e.dir = 1; e.cyc = -1; exp_q.push_back(e);
        end
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (x_step && x_idx == 16'd4) begin hit = 1'b1; break; end
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL abort_reach got timeout want 4th x_step"); end
        abort = 1'b1;
        @(negedge clk);
        tests++;
        if (x_step !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x_idx !== 16'd4) begin
            fails++;
            $display("FAIL abort_state got xs%b b%b d%b xi%0d want 0 0 0 4",
                     x_step, busy, done, x_idx);
        end
        abort = 1'b0;
        repeat (160) @(negedge clk);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL abort_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.kind != e.kind || o.idx != e.idx) begin
                fails++;
                $display("FAIL abort_ev got k%0d i%0d want k%0d i%0d", o.kind, o.idx, e.kind, e.idx);
            end
        end
        clear_all();
    endtask

    task automatic test_start_collision();
        bit  ok;
        bit  hit;
        int  p;
        ev_t e, o;
        clear_all();
        n_pts = 16'd2;
        n_lines = 16'd2;
        @(posedge m50);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        p = cyc;
        push_frame(2, 2, p + 50);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (x_step) begin hit = 1'b1; break; end
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL coll_first got timeout want x_step"); end
        n_pts = 16'd7;
        n_lines = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(700, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL coll_done got timeout want done"); end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL coll_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.kind != e.kind || o.idx != e.idx || o.dir != e.dir || o.cyc != e.cyc) begin
                fails++;
                $display("FAIL coll_ev got k%0d i%0d d%0d c%0d want k%0d i%0d d%0d c%0d",
                         o.kind, o.idx, o.dir, o.cyc, e.kind, e.idx, e.dir, e.cyc);
            end
        end
        clear_all();
    endtask

    task automatic test_direction();
        bit  ok;
        int  p;
        ev_t e, o;
        clear_all();
        do_start(2, 3, p);
        push_frame(2, 3, -1);
        wait_done(800, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL dir_done got timeout want done"); end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL dir_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.kind != e.kind || o.idx != e.idx || o.dir != e.dir) begin
                fails++;
                $display("FAIL dir_ev got k%0d i%0d d%0d want k%0d i%0d d%0d",
                         o.kind, o.idx, o.dir, e.kind, e.idx, e.dir);
            end
        end
        clear_all();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_zero_size();
        test_abort();
        test_start_collision();
        test_direction();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_step_ctrl.md
Name: scan_step_ctrl

Overview:
- Raster scan sequencer that consumes the 50-clk-period divided square wave `m50` produced by the clock-divider stage.
- Each rising edge of `m50` is one scan tick; on each tick the block emits one X step pulse or one Y (line-advance) pulse.
- Once started, it runs a frame of n_pts × n_lines points, then reports done.
- Outputs drive the scanner step/dir interface directly.

Parameters:
- CNT_W, 16, width of n_pts, n_lines, x_idx, y_idx.
- PULSE_W, 4, step pulse high time in clk cycles; legal range 1..24, so a pulse always ends before the next tick.

Ports:
- clk  input  1  system clock; `m50` is generated in this same domain.
- rst  input  1  asynchronous, active-high reset.
- m50  input  1  divided scan clock from the divider stage; 50 clk period, 50% duty.
- start  input  1  one-clk request; latches n_pts/n_lines; honoured only in IDLE.
- abort  input  1  level; stops the scan immediately.
- n_pts  input  CNT_W  X steps per line.
- n_lines  input  CNT_W  lines per frame.
- x_step  output  1  X step pulse, PULSE_W clk wide.
- x_dir  output  1  X direction; 1 = forward.
- y_step  output  1  Y step pulse, PULSE_W clk wide.
- busy  output  1  high from accepted start until done or abort.
- done  output  1  one-clk pulse at frame end.
- x_idx  output  CNT_W  X steps issued in the current line.
- y_idx  output  CNT_W  current line number, 0-based.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0, except x_dir = 1.
  - State = IDLE; m50_d = 0; pulse counters = 0.
- Tick detect:
  - m50_d is `m50` registered once.
  - tick = m50 & ~m50_d, exactly one clk per m50 period.
  - No synchroniser is needed: `m50` is already in the clk domain.
- FSM states: IDLE, RUN_X, LINE, FINISH.
- IDLE:
  - start = 1 with n_pts ≠ 0 and n_lines ≠ 0 → latch both values; x_idx = 0, y_idx = 0, busy = 1 → RUN_X.
  - start with either value 0 → done = 1 for one clk, busy stays 0, no steps.
  - A tick in the same clk as start is ignored; the first step comes on the next tick.
- RUN_X:
  - On tick, x_step rises at that clk edge (registered) and x_idx increments.
  - If the new x_idx == n_pts → LINE.
- LINE (on tick):
  - If y_idx + 1 == n_lines → FINISH.
  - Otherwise y_step pulse, y_idx increments, x_idx = 0 → RUN_X.
- FINISH: done = 1 for one clk, busy = 0 → IDLE. x_idx and y_idx hold their final values until the next start.
- Step pulses:
  - A per-output down-counter is loaded with PULSE_W at the step edge.
  - The output stays high while the counter ≠ 0.
- Frame totals:
  - n_pts × n_lines x_step pulses and n_lines − 1 y_step pulses.
  - done follows the tick after the last X step of the last line.
- abort (any non-IDLE state):
  - Next clk: state = IDLE, busy = 0, x_step = y_step = 0, pulse counters cleared.
  - No done pulse; indices hold.
  - abort has priority over a tick in the same clk. abort in IDLE has no effect.
- start while busy is ignored; latched n_pts and n_lines cannot change mid-frame.
- Asynchronous reset mid-pulse or mid-frame clears everything immediately.
- Counters compare with equality at CNT_W width; n_pts = 2^CNT_W − 1 is legal, and no wrap occurs inside a frame.

Optional Feature:
- Macro: SCAN_SERPENTINE_EN.
- Defined: x_dir toggles in the same clk as each y_step, giving a bidirectional scan, and returns to 1 on start.
- Undefined: x_dir is constant 1 and every line scans forward; the toggle logic is not compiled.

Test Plan:
- Reset then idle: assert rst mid-run → all outputs 0, x_dir = 1; with rst deasserted and no start, toggling m50 produces no steps.
- Basic frame, n_pts = 3, n_lines = 2, m50 period 50 clk:
  - Ticks 1–3 give x_step, each 4 clk wide.
  - Tick 4 gives y_step with y_idx = 1.
  - Ticks 5–7 give x_step.
  - Tick 8 gives done for 1 clk; busy drops in the same clk.
  - Totals: 6 x pulses, 1 y pulse.
- Zero size: start with n_pts = 0, n_lines = 5 → done one clk later; busy never high; no steps.
- Abort: start with n_pts = 10, n_lines = 10; abort after the 4th x_step edge, within the pulse → x_step low next clk, busy = 0, no done, x_idx = 4.
- Start collisions:
  - start coinciding with a tick → first x_step on the following tick, 50 clk later.
  - A second start while busy → no effect on the frame count.
- With SCAN_SERPENTINE_EN defined, n_pts = 2, n_lines = 3 → x_dir sequence 1, 0, 1 per line, toggling on the y_step edges; without the macro, x_dir stays at 1 throughout.
